// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: DEPTH-entry byte FIFO feeding an 8N-STOP_BITS
// serializer that sends LSB first at clk/DIV baud, frames back-to-back.
module uart_tx_fifo #(
   parameter int DIV       = 208,
   parameter int DEPTH     = 16,
   parameter int STOP_BITS = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               wr_data,
   input  logic                     wr_en,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic                     busy,
   output logic                     txd
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   level_q, level_d;
   logic          overflow_q;

   state_e        state_q;
   logic [11:0]   baud_q;
   logic [2:0]    bit_q;
   logic          stop_q;
   logic [7:0]    shift_q;
   logic          txd_q;

   logic push, pop, baud_end, frame_end;

   // DEPTH is a power of two, so the MSB of level alone means level == DEPTH.
   assign full      = level_q[AW];
   assign push      = wr_en && !full;
   assign baud_end  = (baud_q == 12'(DIV - 1));
   assign frame_end = (state_q == STOP) && baud_end && ((STOP_BITS == 1) || stop_q);
   assign pop       = (level_q != '0) && ((state_q == IDLE) || frame_end);

   // NOTE: a default assignment first keeps this block purely combinational (no latch).
   always_comb begin
      level_d = level_q;
      if (push && !pop)
         level_d = level_q + (AW+1)'(1);
      else if (pop && !push)
         level_d = level_q - (AW+1)'(1);
   end

   // NOTE: storage has no reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (!rst && push)
         mem_q[wr_ptr_q] <= wr_data;
   end

   // NOTE: non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push)
            wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)
            rd_ptr_q <= rd_ptr_q + AW'(1);
         level_q <= level_d;
         if (wr_en && full)
            overflow_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         shift_q <= '0;
         txd_q   <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               txd_q <= 1'b1;
               if (pop) begin
                  shift_q <= mem_q[rd_ptr_q];
                  baud_q  <= '0;
                  state_q <= START;
                  txd_q   <= 1'b0;
               end
            end
            START: begin
               if (baud_end) begin
                  baud_q  <= '0;
                  bit_q   <= '0;
                  state_q <= DATA;
                  txd_q   <= shift_q[0];
               end else begin
                  baud_q <= baud_q + 12'd1;
               end
            end
            DATA: begin
               if (baud_end) begin
                  baud_q <= '0;
                  if (bit_q == 3'd7) begin
                     stop_q  <= 1'b0;
                     state_q <= STOP;
                     txd_q   <= 1'b1;
                  end else begin
                     bit_q   <= bit_q + 3'd1;
                     shift_q <= shift_q >> 1;
                     txd_q   <= shift_q[1];
                  end
               end else begin
                  baud_q <= baud_q + 12'd1;
               end
            end
            STOP: begin
               if (baud_end) begin
                  baud_q <= '0;
                  if (frame_end) begin
                     // Chain straight into the next start bit when data is waiting.
                     if (pop) begin
                        shift_q <= mem_q[rd_ptr_q];
                        state_q <= START;
                        txd_q   <= 1'b0;
                     end else begin
                        state_q <= IDLE;
                     end
                  end else begin
                     stop_q <= 1'b1;
                  end
               end else begin
                  baud_q <= baud_q + 12'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign level    = level_q;
   assign overflow = overflow_q;
   assign busy     = (state_q != IDLE) || (level_q != '0);
   assign txd      = txd_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: cycle-level occupancy/timeline model
// plus a UART-decoding monitor that scoreboards received bytes.
module tb_uart_tx_fifo;

   localparam int DIV       = 10;
   localparam int DEPTH     = 16;
   localparam int STOP_BITS = 2;
   localparam int FRAME     = (9 + STOP_BITS) * DIV;

   logic       clk;
   logic       rst;
   logic [7:0] wr_data;
   logic       wr_en;
   logic       full;
   logic [4:0] level;
   logic       overflow;
   logic       busy;
   logic       txd;

   uart_tx_fifo #(.DIV(DIV), .DEPTH(DEPTH), .STOP_BITS(STOP_BITS)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_data  (wr_data),
      .wr_en    (wr_en),
      .full     (full),
      .level    (level),
      .overflow (overflow),
      .busy     (busy),
      .txd      (txd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;

   // Reference model: FIFO contents as a queue, serializer as a timeline.
   logic [7:0] m_fifo [$];
   logic [7:0] exp_q  [$];
   int         m_next_ok = 0;
   int         pop_cyc   = 0;
   bit         frame_on  = 0;
   bit         m_ovf     = 0;
   logic [7:0] cur_byte  = 8'h00;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp)
         passed++;
      else
         $display("FAIL %s: got %0h required %0h at cycle %0d", name, got, exp, cyc);
   endtask

   function automatic logic exp_txd();
      int off, k;
      if (!frame_on) return 1'b1;
      off = cyc - pop_cyc;
      if (off >= FRAME) return 1'b1;
      k = off / DIV;
      if (k == 0) return 1'b0;
      if (k <= 8) return cur_byte[k-1];
      return 1'b1;
   endfunction

   task automatic model_edge(input logic w, input logic [7:0] d, input logic r);
      int pre;
      bit push_m, pop_m;
      if (r) begin
         m_fifo.delete();
         exp_q.delete();
         m_ovf     = 0;
         m_next_ok = 0;
         frame_on  = 0;
      end else begin
         pre    = m_fifo.size();
         push_m = w && (pre < DEPTH);
         if (w && pre == DEPTH) m_ovf = 1;
         pop_m  = (pre > 0) && (cyc >= m_next_ok);
         if (pop_m) begin
            cur_byte  = m_fifo.pop_front();
            pop_cyc   = cyc;
            m_next_ok = cyc + FRAME;
            frame_on  = 1;
         end
         if (push_m) begin
            m_fifo.push_back(d);
            exp_q.push_back(d);
         end
      end
   endtask

   task automatic compare_outputs();
      check("level",    level,    m_fifo.size());
      check("full",     full,     m_fifo.size() == DEPTH);
      check("overflow", overflow, m_ovf);
      check("busy",     busy,     (m_fifo.size() != 0) || (cyc < m_next_ok));
      check("txd",      txd,      exp_txd());
   endtask

   task automatic cycle(input logic w, input logic [7:0] d, input logic r);
      wr_en   = w;
      wr_data = d;
      rst     = r;
      @(posedge clk);
      cyc++;
      model_edge(w, d, r);
      #1;
      compare_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
   endtask

   // Monitor: decodes frames from txd, samples mid-bit, pops the scoreboard.
   int         mcnt = 0;
   bit         mact = 0;
   logic [7:0] mbyte = 8'h00;

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         mact = 0;
      end else begin
         if (!mact && txd === 1'b0) begin
            mact = 1;
            mcnt = 0;
         end
         if (mact) begin
            if (mcnt % DIV == DIV / 2) begin
               if (mcnt / DIV == 0)
                  check("rx_start", txd, 1'b0);
               else if (mcnt / DIV <= 8)
                  mbyte[mcnt / DIV - 1] = txd;
               else
                  check("rx_stop", txd, 1'b1);
            end
            if (mcnt == FRAME - 1) begin
               check("rx_pending", exp_q.size() > 0, 1'b1);
               if (exp_q.size() > 0)
                  check("rx_byte", mbyte, exp_q.pop_front());
               mact = 0;
            end else begin
               mcnt++;
            end
         end
      end
   end

   initial begin
      int rate;
      wr_en   = 1'b0;
      wr_data = 8'h00;
      rst     = 1'b1;

      // Reset and idle state
      for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);
      idle(5);

      // Single byte
      cycle(1'b1, 8'h55, 1'b0);
      check("single_level1", level, 1);
      cycle(1'b0, 8'h00, 1'b0);
      check("single_start_bit", txd, 1'b0);
      idle(130);

      // Burst of three back-to-back frames
      cycle(1'b1, 8'h00, 1'b0);
      cycle(1'b1, 8'hFF, 1'b0);
      cycle(1'b1, 8'hA5, 1'b0);
      check("burst_level", level, 2);
      idle(3 * FRAME + 20);

      // Fill and overflow
      cycle(1'b1, 8'h11, 1'b0);
      idle(2);
      for (int i = 0; i < 17; i++) begin
         cycle(1'b1, 8'(8'h80 + i), 1'b0);
         if (i == 15) begin
            check("fill_full", full, 1'b1);
            check("fill_no_ovf_yet", overflow, 1'b0);
         end
      end
      check("fill_overflow", overflow, 1'b1);
      check("fill_level16", level, DEPTH);

      // Write while full on the exact STOP->START pop edge
      while (cyc + 1 < m_next_ok) cycle(1'b0, 8'h00, 1'b0);
      cycle(1'b1, 8'hEE, 1'b0);
      check("simul_pop_level", level, DEPTH - 1);
      check("simul_pop_ovf", overflow, 1'b1);
      idle(DEPTH * FRAME + 20);
      check("ovf_sticky", overflow, 1'b1);

      // Reset during DATA bit 3 with 4 bytes queued
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0);
      while (cyc < pop_cyc + 4 * DIV + 3) cycle(1'b0, 8'h00, 1'b0);
      cycle(1'b0, 8'h00, 1'b1);
      check("rst_txd", txd, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_level", level, 0);
      check("rst_full", full, 1'b0);
      check("rst_ovf_cleared", overflow, 1'b0);
      idle(200);
      cycle(1'b1, 8'h3C, 1'b0);
      idle(FRAME + 20);

      // Randomized traffic at varying write rates
      for (int b = 0; b < 20; b++) begin
         rate = $urandom_range(0, 100);
         for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 999) == 0)
               cycle(1'b0, 8'h00, 1'b1);
            else
               cycle($urandom_range(0, 99) < rate, 8'($urandom), 1'b0);
         end
      end

      // Drain with a bounded wait
      for (int i = 0; i < 20000 && (m_fifo.size() != 0 || cyc < m_next_ok || mact); i++)
         cycle(1'b0, 8'h00, 1'b0);
      idle(5);
      check("drain_busy", busy, 1'b0);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
